tlul_host_arbiter: RTL



---
 rtl/tlul_arb_pkg.sv | 31 +++
 rtl/tlul_pkg.sv | 34 +++
 rtl/tlul_idx_fifo.sv | 53 +++++
 rtl/tlul_host_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/tlul_arb_pkg.sv
// rtl/tlul_arb_pkg.sv - arbiter state type, default sizing and round-robin pick helper
package tlul_arb_pkg;

    typedef enum logic {ARB, LOCK} arb_state_e;

    localparam int DefNumHosts       = 4;
    localparam int DefMaxOutstanding = 4;
    localparam int RrMaxHosts        = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping within the n active hosts.
    function automatic rr_pick_t rr_pick(input logic [RrMaxHosts-1:0] req,
                                         input logic [3:0] ptr, input int n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int i = 0; i < RrMaxHosts; i++) begin
            cand = (int'(ptr) + i) % n;
            if (i < n && !res.valid && req[cand[3:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL A/D channel types and opcodes shared by the bus fabric
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_idx_fifo.sv
// rtl/tlul_idx_fifo.sv - grant-index FIFO remembering which host owns each in-flight request
module tlul_idx_fifo #(
    parameter int Width = 2,
    parameter int Depth = 4,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr, rptr;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop) rptr <= nxt(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// rtl/tlul_host_arbiter.sv - N-host to one-device TL-UL arbiter; TLUL_ARB_SPURIOUS_RSP_EN adds spurious-response drain
module tlul_host_arbiter
    import tlul_pkg::*;
    import tlul_arb_pkg::*;
#(
    parameter int  NumHosts       = DefNumHosts,
    parameter int  MaxOutstanding = DefMaxOutstanding,
    localparam int HostIdxW       = $clog2(NumHosts),
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  tl_h2d_t         host_req_i [NumHosts],
    output tl_d2h_t         host_rsp_o [NumHosts],
    output tl_h2d_t         dev_req_o,
    input  tl_d2h_t         dev_rsp_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            busy_o
`ifdef TLUL_ARB_SPURIOUS_RSP_EN
    ,
    output logic            spurious_rsp_o
`endif
);
    arb_state_e            state;
    logic [HostIdxW-1:0]   ptr, lock_idx, fwd_idx, head_idx;
    logic [RrMaxHosts-1:0] req_vec;
    rr_pick_t              pick;
    logic                  fwd_valid, a_hs, d_hs, fifo_full, fifo_empty;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NumHosts; i++) req_vec[i] = host_req_i[i].a_valid;
        pick = rr_pick(req_vec, 4'(ptr), NumHosts);

        if (state == LOCK) begin
            fwd_idx   = lock_idx;
            fwd_valid = host_req_i[lock_idx].a_valid;
        end else begin
            fwd_idx   = HostIdxW'(pick.idx);
            fwd_valid = pick.valid;
        end

        a_hs = fwd_valid & ~fifo_full & dev_rsp_i.a_ready;
        d_hs = ~fifo_empty & dev_rsp_i.d_valid & host_req_i[head_idx].d_ready;

        dev_req_o = '0;
        for (int i = 0; i < NumHosts; i++) host_rsp_o[i] = '0;
        if (!rst) begin
            // D routing first so the A-side a_ready below is not overwritten.
            if (!fifo_empty) begin
                host_rsp_o[head_idx]         = dev_rsp_i;
                host_rsp_o[head_idx].a_ready = 1'b0;
            end
            if (fwd_valid && !fifo_full) begin
                dev_req_o                   = host_req_i[fwd_idx];
                host_rsp_o[fwd_idx].a_ready = dev_rsp_i.a_ready;
            end
            if (!fifo_empty) begin
                dev_req_o.d_ready = host_req_i[head_idx].d_ready;
            end else begin
`ifdef TLUL_ARB_SPURIOUS_RSP_EN
                dev_req_o.d_ready = 1'b1;
`else
                dev_req_o.d_ready = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            lock_idx <= '0;
        end else if (a_hs) begin
            state <= ARB;
            ptr   <= (32'(fwd_idx) == NumHosts - 1) ? '0 : fwd_idx + 1'b1;
        end else if (fwd_valid) begin
            state    <= LOCK;
            lock_idx <= fwd_idx;
        end
    end

    tlul_idx_fifo #(
        .Width(HostIdxW),
        .Depth(MaxOutstanding),
        .CntW (CntW)
    ) u_idx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (a_hs),
        .wdata(fwd_idx),
        .pop  (d_hs),
        .rdata(head_idx),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(outstanding_o)
    );

    assign busy_o = (outstanding_o != '0) | (state == LOCK);

`ifdef TLUL_ARB_SPURIOUS_RSP_EN
    always_ff @(posedge clk) begin
        if (rst) spurious_rsp_o <= 1'b0;
        else if (dev_rsp_i.d_valid && fifo_empty) spurious_rsp_o <= 1'b1;
    end
`endif

endmodule
